full_adder: RTL and testbench



---
 rtl/full_adder.sv | 71 +++++++
 tb/tb_full_adder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with a combinational result and an
// enable-gated registered copy of it.
//
// Ports
//   i_clk      rising-edge clock for the registered outputs
//   i_rst      asynchronous active-high reset, clears only the registered outputs
//   i_en       capture enable for the registered outputs
//   i_a, i_b   WIDTH-bit unsigned addends
//   i_c        carry-in to bit 0
//   o_sum      combinational sum bits
//   o_carry    combinational carry-out of the top bit
//   o_sum_q    registered sum
//   o_carry_q  registered carry-out
//   o_valid_q  high once a result has been captured since the last reset
module full_adder #(
  parameter int unsigned WIDTH = 1  // legal range 1..64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_sum_q,
  output logic             o_carry_q,
  output logic             o_valid_q
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_ripple;  // w_ripple[i] is the carry into bit i

  // Ripple chain of 1-bit full-adder cells. Written as one procedural loop so
  // the carry chain is resolved in a single evaluation; X on any input is left
  // to propagate through the plain logic operators.
  always_comb begin
    w_sum    = '0;
    w_ripple = '0;
    w_ripple[0] = i_c;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_sum[i]      = i_a[i] ^ i_b[i] ^ w_ripple[i];
      w_ripple[i+1] = (i_a[i] & i_b[i]) | (w_ripple[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_sum   = w_sum;
  assign o_carry = w_ripple[WIDTH];

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  // Reset wins over any coincident clock edge; en=0 simply holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_sum   <= w_sum;
      r_carry <= w_ripple[WIDTH];
      r_valid <= 1'b1;
    end
  end

  assign o_sum_q   = r_sum;
  assign o_carry_q = r_carry;
  assign o_valid_q = r_valid;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic        a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic        sum1, carry1, sum_q1, carry_q1, valid_q1;
  // WIDTH=4 instance
  logic [3:0]  a4 = '0, b4 = '0;
  logic        c4 = 1'b0;
  logic [3:0]  sum4, sum_q4;
  logic        carry4, carry_q4, valid_q4;
  // WIDTH=16 instance
  logic [15:0] a16 = '0, b16 = '0;
  logic        c16 = 1'b0;
  logic [15:0] sum16, sum_q16;
  logic        carry16, carry_q16, valid_q16;

  full_adder #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a1), .i_b(b1), .i_c(c1),
    .o_sum(sum1), .o_carry(carry1), .o_sum_q(sum_q1), .o_carry_q(carry_q1),
    .o_valid_q(valid_q1)
  );

  full_adder #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a4), .i_b(b4), .i_c(c4),
    .o_sum(sum4), .o_carry(carry4), .o_sum_q(sum_q4), .o_carry_q(carry_q4),
    .o_valid_q(valid_q4)
  );

  full_adder #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_a(a16), .i_b(b16), .i_c(c16),
    .o_sum(sum16), .o_carry(carry16), .o_sum_q(sum_q16), .o_carry_q(carry_q16),
    .o_valid_q(valid_q16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: plain unsigned addition at WIDTH+1 bits.
  function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
    return 2'(a) + 2'(b) + 2'(c);
  endfunction
  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    return 5'(a) + 5'(b) + 5'(c);
  endfunction
  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    a4 = 4'h9; b4 = 4'h8; c4 = 1'b0;
    // Edge coincident with rst must be ignored.
    @(posedge clk); #1;
    n_tests++;
    if ({carry_q1, sum_q1, valid_q1} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_w1: got c=%b s=%b v=%b, want 0 0 0", carry_q1, sum_q1, valid_q1);
    end
    n_tests++;
    if ({carry_q4, sum_q4, valid_q4} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_w4: got c=%b s=%h v=%b, want 0 0 0", carry_q4, sum_q4, valid_q4);
    end
    n_tests++;
    if ({carry_q16, sum_q16, valid_q16} !== 18'b0) begin
      n_fail++;
      $display("FAIL reset_w16: got c=%b s=%h v=%b, want 0 0 0",
               carry_q16, sum_q16, valid_q16);
    end
    // Combinational path keeps working during reset.
    n_tests++;
    if ({carry4, sum4} !== ref4(a4, b4, c4)) begin
      n_fail++;
      $display("FAIL reset_comb_w4: got %h, want %h", {carry4, sum4}, ref4(a4, b4, c4));
    end
    n_tests++;
    if ({carry1, sum1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_comb_w1: got %b, want 10", {carry1, sum1});
    end
    en = 1'b0;
  endtask

  task automatic test_directed_w1();
    logic [2:0] vec [3];
    logic [1:0] want [3];
    vec[0] = 3'b110; want[0] = 2'b10;
    vec[1] = 3'b111; want[1] = 2'b11;
    vec[2] = 3'b010; want[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      {a1, b1, c1} = vec[i];
      #1;
      n_tests++;
      if ({carry1, sum1} !== want[i]) begin
        n_fail++;
        $display("FAIL directed_w1[%0d]: abc=%b got {carry,sum}=%b, want %b",
                 i, vec[i], {carry1, sum1}, want[i]);
      end
    end
  endtask

  task automatic test_exhaustive_w1();
    logic [2:0] abc;
    int         bad = 0;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      {a1, b1, c1} = abc;
      #1;
      n_tests++;
      if ({carry1, sum1} !== ref1(abc[2], abc[1], abc[0])) begin
        n_fail++;
        bad++;
        $display("FAIL exhaustive_w1: abc=%b got %b, want %b",
                 abc, {carry1, sum1}, ref1(abc[2], abc[1], abc[0]));
      end
    end
    $display("[TB] exhaustive W=1 flag=%0d (1 means all 8 combinations matched)", bad == 0);
  endtask

  task automatic test_directed_w4();
    logic [8:0] vec [3];
    logic [4:0] want [3];
    vec[0] = {4'hF, 4'h1, 1'b0}; want[0] = 5'h10;
    vec[1] = {4'hA, 4'h5, 1'b1}; want[1] = 5'h10;
    vec[2] = {4'h0, 4'h0, 1'b1}; want[2] = 5'h01;
    for (int i = 0; i < 3; i++) begin
      {a4, b4, c4} = vec[i];
      #1;
      n_tests++;
      if ({carry4, sum4} !== want[i]) begin
        n_fail++;
        $display("FAIL directed_w4[%0d]: got {carry,sum}=%h, want %h",
                 i, {carry4, sum4}, want[i]);
      end
    end
  endtask

  task automatic test_random_comb();
    for (int i = 0; i < 100; i++) begin
      a4  = 4'($urandom);  b4  = 4'($urandom);  c4  = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      if (i == 0) begin a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1; end
      if (i == 1) begin a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1; end
      #1;
      n_tests++;
      if ({carry4, sum4} !== ref4(a4, b4, c4)) begin
        n_fail++;
        $display("FAIL random_comb_w4: a=%h b=%h c=%b got %h, want %h",
                 a4, b4, c4, {carry4, sum4}, ref4(a4, b4, c4));
      end
      n_tests++;
      if ({carry16, sum16} !== ref16(a16, b16, c16)) begin
        n_fail++;
        $display("FAIL random_comb_w16: a=%h b=%h c=%b got %h, want %h",
                 a16, b16, c16, {carry16, sum16}, ref16(a16, b16, c16));
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    #1;
    n_tests++;
    if (valid_q1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_before_edge: valid_q got %b, want 0", valid_q1);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({carry_q1, sum_q1, valid_q1} !== 3'b101) begin
      n_fail++;
      $display("FAIL reg_capture: got c=%b s=%b v=%b, want 1 0 1", carry_q1, sum_q1, valid_q1);
    end
    @(negedge clk);
    en = 1'b0;
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({carry_q1, sum_q1, valid_q1} !== 3'b101) begin
      n_fail++;
      $display("FAIL reg_hold: got c=%b s=%b v=%b, want 1 0 1", carry_q1, sum_q1, valid_q1);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({carry_q1, sum_q1, valid_q1} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_clear: got c=%b s=%b v=%b, want 0 0 0", carry_q1, sum_q1, valid_q1);
    end
    n_tests++;
    if ({carry1, sum1} !== ref1(a1, b1, c1)) begin
      n_fail++;
      $display("FAIL async_comb: got %b, want %b", {carry1, sum1}, ref1(a1, b1, c1));
    end
    rst = 1'b0; en = 1'b1;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({carry_q1, sum_q1, valid_q1} !== 3'b101) begin
      n_fail++;
      $display("FAIL async_recapture: got c=%b s=%b v=%b, want 1 0 1",
               carry_q1, sum_q1, valid_q1);
    end
    en = 1'b0;
  endtask

  // Random en / mid-cycle resets on the 16-bit instance against a scoreboard.
  task automatic test_random_registered();
    logic [16:0] m_q = '0;
    logic        m_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1; rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      en  = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        #1; rst = 1'b1; #1;
        m_q = '0; m_valid = 1'b0;
        n_tests++;
        if ({carry_q16, sum_q16, valid_q16} !== {m_q, m_valid}) begin
          n_fail++;
          $display("FAIL rand_reg_clear[%0d]: got %h/%b, want 0/0",
                   i, {carry_q16, sum_q16}, valid_q16);
        end
        rst = 1'b0;
      end
      @(posedge clk);
      if (en) begin
        m_q = ref16(a16, b16, c16);
        m_valid = 1'b1;
      end
      #1;
      n_tests++;
      if ({carry_q16, sum_q16, valid_q16} !== {m_q, m_valid}) begin
        n_fail++;
        $display("FAIL rand_reg[%0d]: en=%b got %h/%b, want %h/%b",
                 i, en, {carry_q16, sum_q16}, valid_q16, m_q, m_valid);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    rst = 1'b0;
    test_directed_w1();
    test_exhaustive_w1();
    test_directed_w4();
    test_random_comb();
    test_registered();
    test_async_reset();
    test_random_registered();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
